// File: rtl/sub_serial_4b.sv
// Bit-serial subtractor: diff = in0 - in1 - bin, one bit per cycle via a single full-subtractor cell.
// Latency: nbits+1 cycles from the accept cycle to out_val; one operation per nbits+2 cycles at best.
// Backpressure: in_rdy only in IDLE; out_rdy low holds DONE with diff/bout/ovf/zero frozen.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_val/in_rdy       operand handshake (in0 minuend, in1 subtrahend, bin borrow-in)
//   out_val/out_rdy     result handshake (diff, bout unsigned borrow, ovf signed overflow, zero)

module sub_serial_4b #(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    input  logic             bin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int IW = (nbits > 1) ? $clog2(nbits) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [nbits-1:0] a_q,     a_d;
    logic [nbits-1:0] b_q,     b_d;
    logic             br_q,    br_d;
    // Operand sign bits are kept aside because the operand registers shift away.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [nbits-1:0] diff_q,  diff_d;
    logic             bout_q,  bout_d;
    logic             ovf_q,   ovf_d;
    logic             zero_q,  zero_d;

    // Full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             br_nxt;
    logic [nbits-1:0] diff_shift;

    assign d_bit      = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Bits enter from the MSB side, so after nbits shifts bit 0 sits at diff[0].
    assign diff_shift = {d_bit, diff_q[nbits-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_val) begin
                    a_d     = in0;
                    b_d     = in1;
                    br_d    = bin;
                    a_msb_d = in0[nbits-1];
                    b_msb_d = in1[nbits-1];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_nxt;
                diff_d = diff_shift;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags are taken from the fully assembled result on the DONE-entry edge.
                    bout_d  = br_nxt;
                    zero_d  = ~|diff_shift;
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_shift[nbits-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_rdy  = (state_q == IDLE);
    assign out_val = (state_q == DONE);
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_sub_serial_4b.sv
module tb_sub_serial_4b;

    localparam int NB  = 4;
    localparam int LAT = NB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in0;
    logic [NB-1:0] in1;
    logic          bin;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] diff;
    logic          bout;
    logic          ovf;
    logic          zero;

    always #5 clk = ~clk;

    sub_serial_4b #(.nbits(NB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .bin     (bin),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .diff    (diff),
        .bout    (bout),
        .ovf     (ovf),
        .zero    (zero)
    );

    typedef struct packed {
        logic [NB-1:0] diff;
        logic          bout;
        logic          ovf;
        logic          zero;
    } res_t;

    res_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, independent of the bit-serial recurrence.
    function automatic res_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic bi);
        res_t r;
        int   full;
        full   = int'(a) - int'(b) - int'(bi);
        r.diff = NB'(full & ((1 << NB) - 1));
        r.bout = (int'(a) < int'(b) + int'(bi));
        r.ovf  = (a[NB-1] != b[NB-1]) && (r.diff[NB-1] != a[NB-1]);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        in_val = 1'($urandom);
        in0    = NB'($urandom);
        in1    = NB'($urandom);
        bin    = 1'($urandom);
    endtask

    task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic bi, input int hold);
        int   n;
        res_t snap;
        res_t exp_r;
        n = 0;
        while (!in_rdy && n < 50) begin
            tick();
            n++;
        end
        check("rdy_before_accept", 32'(in_rdy), 32'd1);
        in_val = 1'b1;
        in0    = a;
        in1    = b;
        bin    = bi;
        sb_q.push_back(model(a, b, bi));
        tick();
        n = 1;
        while (!out_val && n < 60) begin
            check("in_rdy_busy", 32'(in_rdy), 32'd0);
            scramble_inputs();
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        snap = {diff, bout, ovf, zero};
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            out_rdy = 1'b0;
            tick();
            check("hold_out_val", 32'(out_val), 32'd1);
            check("hold_in_rdy", 32'(in_rdy), 32'd0);
            check("hold_stable", 32'({diff, bout, ovf, zero}), 32'(snap));
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_r = sb_q.pop_front();
            check("diff", 32'(diff), 32'(exp_r.diff));
            check("bout", 32'(bout), 32'(exp_r.bout));
            check("ovf", 32'(ovf), 32'(exp_r.ovf));
            check("zero", 32'(zero), 32'(exp_r.zero));
        end
        tick();
        out_rdy = 1'b0;
        check("in_rdy_after_take", 32'(in_rdy), 32'd1);
        check("out_val_after_take", 32'(out_val), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_val  = 1'b0;
        in0     = '0;
        in1     = '0;
        bin     = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check("rst_out_val", 32'(out_val), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
        check("post_rst_out_val", 32'(out_val), 32'd0);
        check("post_rst_diff", 32'(diff), 32'd0);
        check("post_rst_bout", 32'(bout), 32'd0);
        check("post_rst_ovf", 32'(ovf), 32'd0);
        check("post_rst_zero", 32'(zero), 32'd0);

        // Directed cases, first one with backpressure.
        do_op(4'd7, 4'd3, 1'b0, 3);
        do_op(4'd3, 4'd7, 1'b0, 0);
        do_op(4'h8, 4'h1, 1'b0, 1);
        do_op(4'h7, 4'hF, 1'b0, 0);
        do_op(4'd5, 4'd4, 1'b1, 0);
        do_op(4'd0, 4'd0, 1'b1, 2);
        do_op(4'hF, 4'hF, 1'b0, 0);

        // Reset in the middle of RUN: nothing must ever be presented.
        in_val = 1'b1;
        in0    = 4'd6;
        in1    = 4'd1;
        bin    = 1'b0;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_rdy", 32'(in_rdy), 32'd1);
        check("midrst_out_val", 32'(out_val), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_result", 32'(out_val), 32'd0);
        end
        do_op(4'd9, 4'd2, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            do_op(NB'($urandom), NB'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
